// File: rtl/aes_encipher.sv
// aes_encipher: iterative AES-128/256 forward cipher, one round per clock,
// requesting each expanded round key by index on `round`.
`default_nettype none

module aes_encipher (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         next,
    input  logic         keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return c_SBOX[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_t         r_state, w_state_nxt;
    logic [3:0]     r_round, w_round_nxt;
    logic [127:0]   r_block, w_block_nxt;
    logic           r_ready, w_ready_nxt;
    logic           r_keylen, w_keylen_nxt;

    logic [7:0]     w_sb [16];
    logic [7:0]     w_sr [16];
    logic [7:0]     w_mc [16];
    logic [127:0]   w_sr_flat;
    logic [127:0]   w_mc_flat;
    logic [3:0]     w_last;

    // Byte i of the state lives at [127-8i -: 8]; i = 4*col + row.
    for (genvar gi = 0; gi < 16; gi++) begin : g_byte
        assign w_sb[gi]                  = sbox(r_block[127-8*gi -: 8]);
        assign w_sr_flat[127-8*gi -: 8]  = w_sr[gi];
        assign w_mc_flat[127-8*gi -: 8]  = w_mc[gi];
    end

    for (genvar gc = 0; gc < 4; gc++) begin : g_col
        for (genvar gr = 0; gr < 4; gr++) begin : g_row
            assign w_sr[4*gc+gr] = w_sb[4*((gc+gr)%4)+gr];
        end
    end

    for (genvar gc = 0; gc < 4; gc++) begin : g_mix
        logic [7:0] w_a0, w_a1, w_a2, w_a3;
        assign w_a0 = w_sr[4*gc+0];
        assign w_a1 = w_sr[4*gc+1];
        assign w_a2 = w_sr[4*gc+2];
        assign w_a3 = w_sr[4*gc+3];
        assign w_mc[4*gc+0] = xt(w_a0) ^ xt(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
        assign w_mc[4*gc+1] = w_a0 ^ xt(w_a1) ^ xt(w_a2) ^ w_a2 ^ w_a3;
        assign w_mc[4*gc+2] = w_a0 ^ w_a1 ^ xt(w_a2) ^ xt(w_a3) ^ w_a3;
        assign w_mc[4*gc+3] = xt(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xt(w_a3);
    end

    assign w_last = r_keylen ? 4'd13 : 4'd9;

    always_comb begin
        w_state_nxt  = r_state;
        w_round_nxt  = r_round;
        w_block_nxt  = r_block;
        w_ready_nxt  = r_ready;
        w_keylen_nxt = r_keylen;
        case (r_state)
            IDLE, DONE: begin
                if (next) begin
                    w_block_nxt  = block;
                    w_keylen_nxt = keylen;
                    w_round_nxt  = 4'd0;
                    w_ready_nxt  = 1'b0;
                    w_state_nxt  = INIT;
                end
            end
            INIT: begin
                w_block_nxt = r_block ^ round_key;
                w_round_nxt = 4'd1;
                w_state_nxt = ROUND;
            end
            ROUND: begin
                w_block_nxt = w_mc_flat ^ round_key;
                w_round_nxt = r_round + 4'd1;
                if (r_round == w_last) begin
                    w_state_nxt = FINAL;
                end
            end
            FINAL: begin
                w_block_nxt = w_sr_flat ^ round_key;
                w_ready_nxt = 1'b1;
                w_state_nxt = DONE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_ready_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_round  <= 4'd0;
            r_block  <= 128'h0;
            r_ready  <= 1'b0;
            r_keylen <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_round  <= w_round_nxt;
            r_block  <= w_block_nxt;
            r_ready  <= w_ready_nxt;
            r_keylen <= w_keylen_nxt;
        end
    end

    assign round     = r_round;
    assign new_block = r_block;
    assign ready     = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_aes_encipher.sv
// tb_aes_encipher: scoreboard bench for aes_encipher with its own key schedule
// and reference cipher (S-box derived from GF(2^8) inversion).
`default_nettype none

module tb_aes_encipher;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         next = 1'b0;
    logic         keylen = 1'b0;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [127:0] block = 128'h0;
    logic [127:0] new_block;
    logic         ready;

    logic [127:0] rk_tab [16];
    logic [7:0]   tb_sbox [256];
    logic [127:0] sb_q [$];
    int           n_chk = 0;
    int           n_pass = 0;
    int           n_fail = 0;

    assign round_key = rk_tab[round];

    always #5 clk = ~clk;

    aes_encipher dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .next      (next),
        .keylen    (keylen),
        .round     (round),
        .round_key (round_key),
        .block     (block),
        .new_block (new_block),
        .ready     (ready)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, v;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
            v = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            tb_sbox[x] = v;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {tb_sbox[w[31:24]], tb_sbox[w[23:16]], tb_sbox[w[15:8]], tb_sbox[w[7:0]]};
    endfunction

    // Round key k occupies [2047-128k -: 128].
    function automatic logic [2047:0] expand(input logic [255:0] key, input logic kl);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [2047:0] rk;
        int            nk, nw;
        nk = kl ? 8 : 4;
        nw = kl ? 60 : 44;
        rc = 8'h01;
        rk = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < nw; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 4 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < nw; i++) rk[2047-32*i -: 32] = w[i];
        return rk;
    endfunction

    function automatic logic [127:0] ref_enc(input logic [127:0] pt, input logic [2047:0] rks,
                                             input logic kl);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] out;
        int           nr;
        nr = kl ? 14 : 10;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rks[2047-8*i -: 8];
        for (int rnd = 1; rnd <= nr; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = tb_sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[4*c+row] = t[4*((c+row)%4)+row];
            if (rnd < nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rks[2047-128*rnd-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
        return out;
    endfunction

    task automatic load_keys(input logic [255:0] key, input logic kl);
        logic [2047:0] rks;
        rks = expand(key, kl);
        for (int k = 0; k < 16; k++) rk_tab[k] = rks[2047-128*k -: 128];
    endtask

    // Called at a negedge; starts an operation immediately (back-to-back if in DONE).
    // pulse_at >= 0 injects a one-cycle next with altered block/keylen while busy.
    task automatic run_op(input logic [255:0] key, input logic kl, input logic [127:0] pt,
                          input logic [127:0] exp, input int pulse_at, input string tag);
        int           nr;
        bit           seq_ok;
        logic [127:0] e;
        nr = kl ? 14 : 10;
        load_keys(key, kl);
        sb_q.push_back(exp);
        next = 1'b1; keylen = kl; block = pt;
        @(posedge clk);
        @(negedge clk);
        next = 1'b0;
        seq_ok = 1'b1;
        for (int k = 0; k <= nr; k++) begin
            if (k > 0) @(negedge clk);
            if (round !== 4'(k) || ready !== 1'b0) seq_ok = 1'b0;
            if (pulse_at >= 0 && k == pulse_at) begin
                next = 1'b1; keylen = ~kl; block = ~pt;
            end else if (pulse_at >= 0 && k == pulse_at + 1) begin
                next = 1'b0; keylen = kl; block = pt;
            end
        end
        next = 1'b0; keylen = kl; block = pt;
        n_chk++;
        if (!seq_ok) begin
            n_fail++;
            $display("FAIL %s round_seq: round/ready did not step 0..%0d with ready low (now round=%0d ready=%b)",
                     tag, nr, round, ready);
        end else n_pass++;
        @(negedge clk);
        n_chk++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s latency: ready=%b after %0d edges, expected 1", tag, ready, nr + 1);
        end else n_pass++;
        for (int w = 0; w < 30 && ready !== 1'b1; w++) @(negedge clk);
        e = sb_q.pop_front();
        n_chk++;
        if (ready !== 1'b1 || new_block !== e) begin
            n_fail++;
            $display("FAIL %s ciphertext: got %h (ready=%b), expected %h", tag, new_block, ready, e);
        end else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++;
        if (round !== 4'd0 || ready !== 1'b0 || new_block !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_state: round=%0d ready=%b new_block=%h, expected 0/0/0",
                     round, ready, new_block);
        end else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fips();
        run_op({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1'b0,
               128'h3243f6a8885a308d313198a2e0370734,
               128'h3925841d02dc09fbdc118597196a0b32, -1, "appB_128");
        run_op({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 1'b0,
               128'h00112233445566778899aabbccddeeff,
               128'h69c4e0d86a7b0430d8cdb78070b4c55a, -1, "appC1_128");
        run_op(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 1'b1,
               128'h00112233445566778899aabbccddeeff,
               128'h8ea2b7ca516745bfeafc49904b496089, -1, "appC3_256");
        repeat (3) @(negedge clk);
        n_chk++;
        if (ready !== 1'b1 || round !== 4'd14 || new_block !== 128'h8ea2b7ca516745bfeafc49904b496089) begin
            n_fail++;
            $display("FAIL done_hold: ready=%b round=%0d new_block=%h, expected 1/14/8ea2b7ca516745bfeafc49904b496089",
                     ready, round, new_block);
        end else n_pass++;
    endtask

    task automatic test_back_to_back();
        run_op({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 1'b0,
               128'h00112233445566778899aabbccddeeff,
               128'h69c4e0d86a7b0430d8cdb78070b4c55a, -1, "b2b_128");
        run_op(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 1'b1,
               128'h00112233445566778899aabbccddeeff,
               128'h8ea2b7ca516745bfeafc49904b496089, -1, "b2b_256");
        run_op({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1'b0,
               128'h3243f6a8885a308d313198a2e0370734,
               128'h3925841d02dc09fbdc118597196a0b32, 5, "busy_pulse_128");
        run_op(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 1'b1,
               128'h00112233445566778899aabbccddeeff,
               128'h8ea2b7ca516745bfeafc49904b496089, 0, "busy_pulse_init_256");
    endtask

    task automatic test_reset_mid();
        int w;
        load_keys({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 1'b0);
        next = 1'b1; keylen = 1'b0; block = 128'h00112233445566778899aabbccddeeff;
        @(posedge clk);
        @(negedge clk);
        next = 1'b0;
        w = 0;
        while (round !== 4'd5 && w < 20) begin
            @(negedge clk);
            w++;
        end
        n_chk++;
        if (round !== 4'd5) begin
            n_fail++;
            $display("FAIL reset_mid_reach: round=%0d, expected 5", round);
        end else n_pass++;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (round !== 4'd0 || ready !== 1'b0 || new_block !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_mid_async: round=%0d ready=%b new_block=%h, expected 0/0/0",
                     round, ready, new_block);
        end else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        n_chk++;
        if (ready !== 1'b0 || round !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_mid_no_result: ready=%b round=%0d, expected 0/0", ready, round);
        end else n_pass++;
        run_op({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 1'b0,
               128'h00112233445566778899aabbccddeeff,
               128'h69c4e0d86a7b0430d8cdb78070b4c55a, -1, "after_reset_128");
    endtask

    task automatic test_regression();
        logic [255:0] key;
        logic [127:0] pt, exp;
        int           f0;
        for (int kl = 0; kl < 2; kl++) begin
            f0 = n_fail;
            for (int n = 0; n < 100; n++) begin
                key = {$urandom(), $urandom(), $urandom(), $urandom(),
                       $urandom(), $urandom(), $urandom(), $urandom()};
                pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
                exp = ref_enc(pt, expand(key, 1'(kl)), 1'(kl));
                run_op(key, 1'(kl), pt, exp, -1, kl ? "rand_256" : "rand_128");
            end
            $display("AES-%0d regression: %0d errors", kl ? 256 : 128, n_fail - f0);
        end
    endtask

    initial begin
        for (int k = 0; k < 16; k++) rk_tab[k] = 128'h0;
        build_sbox();
        test_reset();
        test_fips();
        test_back_to_back();
        test_reset_mid();
        test_regression();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
